// File: rtl/kernel_write_divider_pipe_if.sv
// Bundles the request and result handshakes of kernel_write_divider_pipe.
//   master : host side (drives request, drives o_ready, observes result)
//   slave  : divider side (accepts request, presents result)
// Request  : i_valid, i_ready, dividend, divisor, i_data
// Result   : o_valid, o_ready, quotient, remainder, o_data, o_ovf
//            and o_div_zero when KWD_DIV_ZERO_FLAG_EN is defined.
// DATA_WIDTH=0 still carries 1-bit data nets; the divider ties o_data to 0.
interface kernel_write_divider_pipe_if #(
  parameter int unsigned DIVIDEND_WIDTH = 20,
  parameter int unsigned DIVISOR_WIDTH  = 10,
  parameter int unsigned QUOTIENT_WIDTH = 10,
  parameter int unsigned DATA_WIDTH     = 16
);
  localparam int unsigned DW = (DATA_WIDTH > 0) ? DATA_WIDTH : 1;

  logic                      i_valid;
  logic                      i_ready;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic [DW-1:0]             i_data;
  logic                      o_valid;
  logic                      o_ready;
  logic [QUOTIENT_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH-1:0]  remainder;
  logic [DW-1:0]             o_data;
  logic                      o_ovf;
`ifdef KWD_DIV_ZERO_FLAG_EN
  logic                      o_div_zero;
`endif

  modport master (
    output i_valid, dividend, divisor, i_data, o_ready,
    input  i_ready, o_valid, quotient, remainder, o_data, o_ovf
`ifdef KWD_DIV_ZERO_FLAG_EN
    , input o_div_zero
`endif
  );

  modport slave (
    input  i_valid, dividend, divisor, i_data, o_ready,
    output i_ready, o_valid, quotient, remainder, o_data, o_ovf
`ifdef KWD_DIV_ZERO_FLAG_EN
    , output o_div_zero
`endif
  );
endinterface

// File: rtl/kernel_write_divider_pipe.sv
// Pipelined restoring divider: splits a flat kernel-write address (dividend) into
// (row = quotient, offset = remainder) for a runtime kernel depth (divisor).
// Stage 0 registers operands and the overflow check; stages 1..QUOTIENT_WIDTH each
// resolve one quotient bit, MSB first. Latency QUOTIENT_WIDTH+1, one result per cycle.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (clears valid bits only)
//   bus   : kernel_write_divider_pipe_if.slave (request/result handshakes)
// Optional feature: define KWD_DIV_ZERO_FLAG_EN to add o_div_zero (divisor==0 flag).
// Overflow (quotient would not fit, incl. divisor==0) yields quotient all-ones,
// remainder 0 and o_ovf=1.
module kernel_write_divider_pipe #(
  parameter int unsigned DIVIDEND_WIDTH = 20,
  parameter int unsigned DIVISOR_WIDTH  = 10,
  parameter int unsigned QUOTIENT_WIDTH = 10,
  parameter int unsigned DATA_WIDTH     = 16
) (
  input logic                         clk,
  input logic                         rst_n,
  kernel_write_divider_pipe_if.slave  bus
);
  localparam int unsigned Q  = QUOTIENT_WIDTH;
  localparam int unsigned DW = (DATA_WIDTH > 0) ? DATA_WIDTH : 1;
  // Trial subtraction width: holds the dividend and the largest shifted divisor plus a sign.
  localparam int unsigned TW = ((DIVIDEND_WIDTH > DIVISOR_WIDTH + Q - 1) ?
                                DIVIDEND_WIDTH : DIVISOR_WIDTH + Q - 1) + 1;
  localparam int unsigned CW = (DIVIDEND_WIDTH > DIVISOR_WIDTH) ? DIVIDEND_WIDTH : DIVISOR_WIDTH;

  logic                      adv;
  logic [Q:0]                valid_q;
  logic [DIVIDEND_WIDTH-1:0] rem_q  [Q+1];
  logic [DIVISOR_WIDTH-1:0]  div_q  [Q+1];
  logic [Q-1:0]              quo_q  [Q+1];
  logic [DW-1:0]             data_q [Q+1];
  logic [Q:0]                ovf_q;
`ifdef KWD_DIV_ZERO_FLAG_EN
  logic [Q:0]                dz_q;
`endif

  logic [DIVIDEND_WIDTH-1:0] rem_d [1:Q];
  logic [Q-1:0]              quo_d [1:Q];
  logic [TW-1:0]             trial;
  logic                      ovf_in;

  // Whole pipe moves together; bubbles are kept, so stalling depends only on the last stage.
  assign adv         = ~valid_q[Q] | bus.o_ready;
  assign bus.i_ready = adv;

  assign ovf_in = CW'(bus.dividend >> Q) >= CW'(bus.divisor);

  always_comb begin
    trial = '0;
    for (int k = 1; k <= int'(Q); k++) begin
      rem_d[k] = rem_q[k-1];
      quo_d[k] = quo_q[k-1];
      trial    = TW'(rem_q[k-1]) - (TW'(div_q[k-1]) << (int'(Q) - k));
      if (!trial[TW-1]) begin
        rem_d[k]            = trial[DIVIDEND_WIDTH-1:0];
        quo_d[k][int'(Q)-k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q <= {valid_q[Q-1:0], bus.i_valid};
    end
  end

  // Payload registers carry no reset; they are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (adv) begin
      rem_q[0]  <= bus.dividend;
      div_q[0]  <= bus.divisor;
      quo_q[0]  <= '0;
      data_q[0] <= bus.i_data;
      ovf_q[0]  <= ovf_in;
`ifdef KWD_DIV_ZERO_FLAG_EN
      dz_q[0]   <= (bus.divisor == '0);
`endif
      for (int k = 1; k <= int'(Q); k++) begin
        rem_q[k]  <= rem_d[k];
        div_q[k]  <= div_q[k-1];
        quo_q[k]  <= quo_d[k];
        data_q[k] <= data_q[k-1];
        ovf_q[k]  <= ovf_q[k-1];
`ifdef KWD_DIV_ZERO_FLAG_EN
        dz_q[k]   <= dz_q[k-1];
`endif
      end
    end
  end

  assign bus.o_valid   = valid_q[Q];
  assign bus.o_ovf     = valid_q[Q] & ovf_q[Q];
  assign bus.quotient  = ovf_q[Q] ? '1 : quo_q[Q];
  assign bus.remainder = ovf_q[Q] ? '0 : rem_q[Q][DIVISOR_WIDTH-1:0];
`ifdef KWD_DIV_ZERO_FLAG_EN
  assign bus.o_div_zero = valid_q[Q] & dz_q[Q];
`endif

  if (DATA_WIDTH > 0) begin : g_data
    assign bus.o_data = data_q[Q];
  end else begin : g_no_data
    assign bus.o_data = '0;
  end
endmodule

// File: tb/tb_kernel_write_divider_pipe.sv
// Self-checking bench for kernel_write_divider_pipe with default parameters.
// A scoreboard queue receives reference results on every accepted request and is
// popped on every result handshake.
module tb_kernel_write_divider_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kernel_write_divider_pipe_if bus ();

  kernel_write_divider_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [9:0]  q;
    logic [9:0]  r;
    logic        ovf;
    logic        dz;
    logic [15:0] data;
    int          cyc;
    bit          strict;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_mode = 1'b1;
  bit   bp_mode = 1'b0;

  bit          stalled_prev = 1'b0;
  logic [9:0]  s_q, s_r;
  logic        s_ovf;
  logic [15:0] s_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [19:0] dd, input logic [9:0] dv,
                                 input logic [15:0] d);
    exp_t        e;
    int unsigned a, b;
    a = dd;
    b = dv;
    e.data   = d;
    e.dz     = (b == 0);
    e.cyc    = cyc;
    e.strict = lat_mode;
    if (b == 0 || (a / b) > 1023) begin
      e.ovf = 1'b1;
      e.q   = 10'h3ff;
      e.r   = 10'd0;
    end else begin
      e.ovf = 1'b0;
      e.q   = 10'(a / b);
      e.r   = 10'(a % b);
    end
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Downstream ready: always 1, or 50% random under backpressure.
  initial begin
    bus.o_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.o_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: handshake rule, stall stability, scoreboard pop/push.
  always @(negedge clk) begin
    logic exp_rdy;
    exp_t e;
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        check_eq("stall_valid", bus.o_valid, 1'b1);
        check_eq("stall_quot", bus.quotient, s_q);
        check_eq("stall_rem", bus.remainder, s_r);
        check_eq("stall_ovf", bus.o_ovf, s_ovf);
        check_eq("stall_data", bus.o_data, s_data);
      end
      exp_rdy = !bus.o_valid || bus.o_ready;
      check_eq("i_ready", bus.i_ready, exp_rdy);
      if (bus.o_valid && bus.o_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_out", bus.o_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check_eq("quotient", bus.quotient, e.q);
          check_eq("remainder", bus.remainder, e.r);
          check_eq("ovf", bus.o_ovf, e.ovf);
          check_eq("data", bus.o_data, e.data);
`ifdef KWD_DIV_ZERO_FLAG_EN
          check_eq("div_zero", bus.o_div_zero, e.dz);
`endif
          if (e.strict) check_eq("latency", cyc - e.cyc, 11);
        end
      end
      stalled_prev = bus.o_valid && !bus.o_ready;
      s_q    = bus.quotient;
      s_r    = bus.remainder;
      s_ovf  = bus.o_ovf;
      s_data = bus.o_data;
      if (bus.i_valid && bus.i_ready) sb.push_back(model(bus.dividend, bus.divisor, bus.i_data));
    end
  end

  // Called 1 time unit after a rising edge; returns likewise, after the accept edge.
  task automatic send(input logic [19:0] dd, input logic [9:0] dv, input logic [15:0] d);
    int n = 0;
    bus.i_valid  = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.i_data   = d;
    @(negedge clk);
    while (!bus.i_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_wait", n < 1000, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.i_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    bus.i_valid = 1'b0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("drain", sb.size() == 0, 1'b1);
  endtask

  initial begin
    logic [9:0]  dv;
    logic [19:0] dd;
    bus.i_valid  = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.i_data   = '0;

    #3;
    check_eq("rst_o_valid", bus.o_valid, 1'b0);
    check_eq("rst_i_ready", bus.i_ready, 1'b1);
    check_eq("rst_o_ovf", bus.o_ovf, 1'b0);
`ifdef KWD_DIV_ZERO_FLAG_EN
    check_eq("rst_div_zero", bus.o_div_zero, 1'b0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed: basic, quotient boundary, first overflow, divide by zero.
    send(20'd1000, 10'd288, 16'h00a1);
    send(20'd294911, 10'd288, 16'h00a2);
    send(20'd294912, 10'd288, 16'h00a3);
    send(20'd5, 10'd0, 16'h00a4);
    drain();

    // Back-to-back stream, no stalls.
    for (int i = 0; i < 64; i++) begin
      dv = 10'($urandom_range(1, 1023));
      if (i % 2 == 1) dd = 20'($urandom_range(0, int'(dv) * 1024 - 1));
      else dd = 20'($urandom);
      send(dd, dv, 16'(i));
    end
    drain();

    // Backpressure with occasional input bubbles; divisor 0 allowed here.
    lat_mode = 1'b0;
    bp_mode  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      dv = 10'($urandom_range(0, 1023));
      dd = (i % 2 == 1 && dv != 0) ? 20'($urandom_range(0, int'(dv) * 1024 - 1))
                                   : 20'($urandom);
      send(dd, dv, 16'(16'h100 + i));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();
    bp_mode  = 1'b0;
    lat_mode = 1'b1;
    idle(2);

    // Reset with operations in flight.
    for (int i = 0; i < 5; i++) send(20'(1000 + i), 10'd288, 16'(16'h200 + i));
    bus.i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_flush_valid", bus.o_valid, 1'b0);
    check_eq("rst_flush_ovf", bus.o_ovf, 1'b0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      check_eq("no_stale", bus.o_valid, 1'b0);
    end
    send(20'd77777, 10'd100, 16'h0300);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
